// File: rtl/tpram_stream_reader.sv
// Read-side master for the two-port RAM: turns (start address, length) commands into
// RAM reads and streams the words out through a small skid FIFO. Optional OUT_LAST via TPRAM_STREAM_READER_LAST_EN.
module tpram_stream_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int FIFO_DEPTH = 4,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  START,
    input  logic [AW-1:0]         START_ADDR,
    input  logic [AW:0]           LEN,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  CENA,
    output logic [AW-1:0]         AA,
    input  logic [DATA_WIDTH-1:0] QA,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [DATA_WIDTH-1:0] OUT_DATA,
`ifdef TPRAM_STREAM_READER_LAST_EN
    output logic                  OUT_LAST,
`endif
    output logic [1:0]            DBG_STATE
);

    // Stream handshake: a beat transfers on a rising edge with OUT_VALID && OUT_READY;
    // once raised, OUT_VALID and OUT_DATA hold until that transfer happens.

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]   FIFO_CAP = (PW+1)'(FIFO_DEPTH);
    localparam logic [AW-1:0] ADDR_MAX = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [AW:0]     rem_q, rem_d;
    logic [AW-1:0]   aa_q, aa_d;
    logic            done_q, done_d;
    logic            inflight_q;
    logic            issue;
    logic            push, pop;
    logic [PW:0]     occ;

    logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [PW:0]           count_q;

    assign push = inflight_q;
    assign pop  = OUT_VALID && OUT_READY;
    assign occ  = count_q + {{PW{1'b0}}, inflight_q};

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        aa_d    = aa_q;
        done_d  = 1'b0;
        issue   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    if (LEN != '0) begin
                        addr_d  = START_ADDR;
                        rem_d   = LEN;
                        state_d = S_RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                // Reads in flight count against FIFO space, so a landing word always fits.
                if (rem_q != '0 && occ < FIFO_CAP) begin
                    issue  = 1'b1;
                    aa_d   = addr_q;
                    addr_d = (addr_q == ADDR_MAX) ? '0 : AW'(addr_q + 1'b1);
                    rem_d  = rem_q - 1'b1;
                    if (rem_q == (AW+1)'(1)) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!inflight_q && count_q == (PW+1)'(1) && pop) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            aa_q       <= '0;
            done_q     <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            aa_q       <= aa_d;
            done_q     <= done_d;
            inflight_q <= issue;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_data_q[i] <= '0;
        end else begin
            if (push) begin
                fifo_data_q[wr_ptr_q] <= QA;
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef TPRAM_STREAM_READER_LAST_EN
    logic inflight_last_q;
    logic fifo_last_q [FIFO_DEPTH];

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            inflight_last_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_last_q[i] <= 1'b0;
        end else begin
            inflight_last_q <= issue && (rem_q == (AW+1)'(1));
            if (push) fifo_last_q[wr_ptr_q] <= inflight_last_q;
        end
    end

    assign OUT_LAST = OUT_VALID && fifo_last_q[rd_ptr_q];
`endif

    assign BUSY      = (state_q != S_IDLE);
    assign DONE      = done_q;
    assign CENA      = ~issue;
    // AA keeps showing the last issued address while no read is issued.
    assign AA        = issue ? addr_q : aa_q;
    assign OUT_VALID = (count_q != '0);
    assign OUT_DATA  = fifo_data_q[rd_ptr_q];
    assign DBG_STATE = state_q;

endmodule
